led_display_panel_rx: RTL and testbench
=======================================

LED_DISPLAY_PANEL_RX -- requirements
Module: led_display_panel_rx

Interface
REQ-001 SHALL have parameter SYS_CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter NUM_ROW_PIXELS, default 32, panel rows.
REQ-003 SHALL have parameter NUM_COL_PIXELS, default 64, panel columns.
REQ-004 SHALL have localparam ADDR_W = clog2(NUM_ROW_PIXELS/2), which is 4 at defaults.
REQ-005 SHALL have port clk_in, input, 1, the single system clock; all logic is on its rising edge.
REQ-006 SHALL have port n_reset_in, input, 1, reset that is asynchronous and active-low.
REQ-007 SHALL have port bclk_in, input, 1, panel bit clock, asynchronous to clk_in.
REQ-008 SHALL have port rgb_top_in, input, 3, {r,g,b} for the upper-half pixel.
REQ-009 SHALL have port rgb_bot_in, input, 3, {r,g,b} for the lower-half pixel.
REQ-010 SHALL have port latch_in, input, 1, row latch strobe, active-high.
REQ-011 SHALL have port oe_n_in, input, 1, output enable, active-low.
REQ-012 SHALL have port addr_in, input, ADDR_W, row address.
REQ-013 SHALL have port row_top_out, output, 3*NUM_COL_PIXELS, captured upper row; column c occupies bits [3c+2:3c] as {r,g,b}.
REQ-014 SHALL have port row_bot_out, output, 3*NUM_COL_PIXELS, captured lower row, same layout.
REQ-015 SHALL have port row_addr_out, output, ADDR_W, addr_in value sampled at the latch edge.
REQ-016 SHALL have port row_valid_out, output, 1, captured row available.
REQ-017 SHALL have port row_ready_in, input, 1, consumer accepts the row.
REQ-018 SHALL have port on_time_out, output, 16, clk_in cycles with oe_n low since the previous latch (sampled at the latch).
REQ-019 SHALL have port len_err_out, output, 1, sticky flag: latch received with bit count not equal to NUM_COL_PIXELS.
REQ-020 SHALL have port overrun_out, output, 1, sticky flag: latch received while row_valid_out is high.
REQ-021 SHALL have port err_clr_in, input, 1, synchronous clear of both sticky flags.

Function
REQ-022 SHALL pass bclk_in, rgb_top_in, rgb_bot_in, latch_in, oe_n_in and addr_in each through a 2-flop synchronizer; all edge detection SHALL act on synchronized values only.
REQ-023 SHALL shift synchronized rgb_top/rgb_bot into their column shift registers on each synchronized bclk rising edge; the first pixel shifted after a latch lands at column NUM_COL_PIXELS-1 and the last at column 0.
REQ-024 SHALL keep a 7-bit bit counter: it increments per bclk edge, saturates at NUM_COL_PIXELS+1, and resets to 0 on each latch edge.
REQ-025 SHALL implement the FSM states IDLE (count=0), SHIFT (0<count<NUM_COL_PIXELS), FULL (count=NUM_COL_PIXELS) and LONG (count>NUM_COL_PIXELS); a bclk edge in LONG keeps shifting and stays in LONG.
REQ-026 SHALL, on a synchronized latch rising edge with row_valid_out low, copy the shift registers, addr and the oe counter to the outputs and set row_valid_out one clk_in cycle after the detected edge.
REQ-027 SHALL set len_err_out on a latch edge in any state other than FULL; the row SHALL still be transferred.
REQ-028 SHALL, on a latch edge while row_valid_out is high, set overrun_out, leave the held outputs unchanged, and still reset the bit counter and oe counter.
REQ-029 SHALL hold row_valid_out and all row outputs stable until a cycle with row_ready_in=1, then clear row_valid_out the next cycle.
REQ-030 SHALL, when a latch edge and the handshake complete in the same cycle, treat it as an overrun; the new row is dropped.
REQ-031 SHALL count clk_in cycles with synchronized oe_n low, saturating at 16'hFFFF, cleared on each latch edge after sampling.
REQ-032 SHALL let err_clr_in clear the sticky flags; a set event in the same cycle SHALL win.
REQ-033 SHALL ignore bclk edges coincident with a latch edge; such an edge is neither shifted nor counted.

Reset
REQ-034 SHALL, while n_reset_in is low, immediately drive all outputs, shift registers, counters and synchronizers to 0 and the FSM to IDLE.
REQ-035 SHALL, on reset mid-row, discard the partial row; no row_valid_out is produced until a new latch after reset.

Verification
REQ-036 SHALL verify: 64 bclk edges with top=pixel index mod 8, bot=~top, then latch with addr=5 -> row_valid=1, row_addr_out=5, column 0 holds pixel 63, len_err=0.
REQ-037 SHALL verify: 63 edges then latch, and separately 65 edges then latch -> len_err=1 in both cases, row delivered.
REQ-038 SHALL verify: two rows with row_ready_in held 0 -> first row retained unchanged, overrun=1; after ready, row_valid drops after 1 cycle.
REQ-039 SHALL verify: oe_n low for 500 clk cycles between latches -> on_time_out=500; oe_n low for more than 65535 cycles -> 65535.
REQ-040 SHALL verify: reset asserted after 30 edges, released, then 64 edges and latch -> clean row, no errors.
REQ-041 SHALL verify: err_clr_in pulsed -> both flags return to 0 the next cycle.

Source files
------------

// File: rtl/led_display_panel_rx.sv
// led_display_panel_rx
//   Receives one row pair of a HUB75-style LED panel from an external driver.
//   All panel inputs are asynchronous and pass through 2-flop synchronizers.
//   The synchronized bit clock shifts pixels into two column shift registers.
//   The synchronized latch strobe hands the captured row to a valid/ready
//   consumer. The outputs are also the oe-low on-time and the sticky
//   length/overrun error flags.
//
// Ports
//   clk_in         system clock, all logic on rising edge
//   n_reset_in     asynchronous active-low reset
//   bclk_in        panel bit clock (asynchronous)
//   rgb_top_in     {r,g,b} upper-half pixel
//   rgb_bot_in     {r,g,b} lower-half pixel
//   latch_in       row latch strobe, active-high
//   oe_n_in        output enable, active-low
//   addr_in        row address
//   row_top_out    captured upper row, column c at [3c+2:3c]
//   row_bot_out    captured lower row, same layout
//   row_addr_out   addr_in sampled at the latch edge
//   row_valid_out  captured row available
//   row_ready_in   consumer accepts the row
//   on_time_out    clk_in cycles with oe_n low since the previous latch
//   len_err_out    sticky: latch with bit count != NUM_COL_PIXELS
//   overrun_out    sticky: latch while a row was still pending
//   err_clr_in     synchronous clear of both sticky flags
module led_display_panel_rx #(
  parameter int SYS_CLK_FREQ   = 100_000_000,
  parameter int NUM_ROW_PIXELS = 32,
  parameter int NUM_COL_PIXELS = 64,
  localparam int ADDR_W        = $clog2(NUM_ROW_PIXELS / 2)
) (
  input  logic                        clk_in,
  input  logic                        n_reset_in,
  input  logic                        bclk_in,
  input  logic [2:0]                  rgb_top_in,
  input  logic [2:0]                  rgb_bot_in,
  input  logic                        latch_in,
  input  logic                        oe_n_in,
  input  logic [ADDR_W-1:0]           addr_in,
  output logic [3*NUM_COL_PIXELS-1:0] row_top_out,
  output logic [3*NUM_COL_PIXELS-1:0] row_bot_out,
  output logic [ADDR_W-1:0]           row_addr_out,
  output logic                        row_valid_out,
  input  logic                        row_ready_in,
  output logic [15:0]                 on_time_out,
  output logic                        len_err_out,
  output logic                        overrun_out,
  input  logic                        err_clr_in
);

  localparam int ROW_W = 3 * NUM_COL_PIXELS;
  localparam logic [6:0] CNT_FULL = 7'(NUM_COL_PIXELS);
  localparam logic [6:0] CNT_SAT  = 7'(NUM_COL_PIXELS + 1);

  // Elaboration-time sanity checks on the parameters.
  if (SYS_CLK_FREQ < 1) begin : g_bad_freq
    $error("SYS_CLK_FREQ must be positive");
  end
  if (NUM_COL_PIXELS < 2 || NUM_COL_PIXELS > 126) begin : g_bad_cols
    $error("NUM_COL_PIXELS must be in 2..126 for the 7-bit bit counter");
  end

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FULL,
    LONG
  } state_e;

  // ---------------------------------------------------------------------
  // Input synchronizers (2 flops each) plus one history flop for edges
  // ---------------------------------------------------------------------
  logic [1:0]        bclk_sync_q;
  logic [1:0]        latch_sync_q;
  logic [1:0]        oe_sync_q;
  logic [2:0]        top_s1_q, top_s2_q;
  logic [2:0]        bot_s1_q, bot_s2_q;
  logic [ADDR_W-1:0] addr_s1_q, addr_s2_q;
  logic              bclk_prev_q;
  logic              latch_prev_q;

  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      bclk_sync_q  <= '0;
      latch_sync_q <= '0;
      oe_sync_q    <= '0;
      top_s1_q     <= '0;
      top_s2_q     <= '0;
      bot_s1_q     <= '0;
      bot_s2_q     <= '0;
      addr_s1_q    <= '0;
      addr_s2_q    <= '0;
      bclk_prev_q  <= 1'b0;
      latch_prev_q <= 1'b0;
    end else begin
      bclk_sync_q  <= {bclk_sync_q[0], bclk_in};
      latch_sync_q <= {latch_sync_q[0], latch_in};
      oe_sync_q    <= {oe_sync_q[0], oe_n_in};
      top_s1_q     <= rgb_top_in;
      top_s2_q     <= top_s1_q;
      bot_s1_q     <= rgb_bot_in;
      bot_s2_q     <= bot_s1_q;
      addr_s1_q    <= addr_in;
      addr_s2_q    <= addr_s1_q;
      bclk_prev_q  <= bclk_sync_q[1];
      latch_prev_q <= latch_sync_q[1];
    end
  end

  logic bclk_rise;
  logic latch_rise;
  logic shift_en;
  logic oe_low;

  assign bclk_rise  = bclk_sync_q[1] & ~bclk_prev_q;
  assign latch_rise = latch_sync_q[1] & ~latch_prev_q;
  // A bit clock edge landing on the latch edge belongs to neither row.
  assign shift_en   = bclk_rise & ~latch_rise;
  assign oe_low     = ~oe_sync_q[1];

  // ---------------------------------------------------------------------
  // Column shift registers: new pixel enters column 0 and moves upward,
  // so the first pixel of a full row ends at column NUM_COL_PIXELS-1.
  // ---------------------------------------------------------------------
  logic [ROW_W-1:0] top_sr_q;
  logic [ROW_W-1:0] bot_sr_q;

  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      top_sr_q <= '0;
      bot_sr_q <= '0;
    end else if (shift_en) begin
      top_sr_q <= {top_sr_q[ROW_W-4:0], top_s2_q};
      bot_sr_q <= {bot_sr_q[ROW_W-4:0], bot_s2_q};
    end
  end

  // ---------------------------------------------------------------------
  // Bit counter and row-length FSM
  // ---------------------------------------------------------------------
  state_e     state_q;
  logic [6:0] cnt_q;

  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else if (latch_rise) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else if (shift_en) begin
      if (cnt_q != CNT_SAT) begin
        cnt_q <= cnt_q + 7'd1;
      end
      case (state_q)
        IDLE:    state_q <= (CNT_FULL == 7'd1) ? FULL : SHIFT;
        SHIFT:   state_q <= (cnt_q + 7'd1 == CNT_FULL) ? FULL : SHIFT;
        FULL:    state_q <= LONG;
        LONG:    state_q <= LONG;
        default: state_q <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Output-enable on-time counter (saturating, cleared at each latch)
  // ---------------------------------------------------------------------
  logic [15:0] oe_cnt_q;

  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      oe_cnt_q <= '0;
    end else if (latch_rise) begin
      oe_cnt_q <= '0;
    end else if (oe_low && oe_cnt_q != '1) begin
      oe_cnt_q <= oe_cnt_q + 16'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Row hand-off and sticky flags
  // ---------------------------------------------------------------------
  logic [ROW_W-1:0]  row_top_q, row_bot_q;
  logic [ADDR_W-1:0] row_addr_q;
  logic [15:0]       on_time_q;
  logic              valid_q, valid_d;
  logic              len_err_q, len_err_d;
  logic              overrun_q, overrun_d;
  logic              capture;
  logic              len_set;
  logic              ovr_set;

  // The latch check uses the registered valid, so a latch arriving in the
  // same cycle as the accepting handshake still counts as an overrun.
  assign capture = latch_rise & ~valid_q;
  assign ovr_set = latch_rise & valid_q;
  assign len_set = latch_rise & (state_q != FULL);

  always_comb begin
    valid_d = valid_q;
    if (capture) begin
      valid_d = 1'b1;
    end else if (valid_q && row_ready_in) begin
      valid_d = 1'b0;
    end

    len_err_d = len_err_q;
    if (len_set) begin
      len_err_d = 1'b1;
    end else if (err_clr_in) begin
      len_err_d = 1'b0;
    end

    overrun_d = overrun_q;
    if (ovr_set) begin
      overrun_d = 1'b1;
    end else if (err_clr_in) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      row_top_q  <= '0;
      row_bot_q  <= '0;
      row_addr_q <= '0;
      on_time_q  <= '0;
      valid_q    <= 1'b0;
      len_err_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      if (capture) begin
        row_top_q  <= top_sr_q;
        row_bot_q  <= bot_sr_q;
        row_addr_q <= addr_s2_q;
        on_time_q  <= oe_cnt_q;
      end
      valid_q   <= valid_d;
      len_err_q <= len_err_d;
      overrun_q <= overrun_d;
    end
  end

  assign row_top_out   = row_top_q;
  assign row_bot_out   = row_bot_q;
  assign row_addr_out  = row_addr_q;
  assign row_valid_out = valid_q;
  assign on_time_out   = on_time_q;
  assign len_err_out   = len_err_q;
  assign overrun_out   = overrun_q;

endmodule

// File: tb/tb_led_display_panel_rx.sv
// tb_led_display_panel_rx
//   Randomized scoreboard bench for led_display_panel_rx. Stimulus tasks drive
//   the panel interface and a pixel-history model predicts each delivered
//   row. A negedge monitor pops and compares on every valid/ready handshake.
`timescale 1ns/1ps
module tb_led_display_panel_rx;

  localparam int N   = 64;
  localparam int RW  = 3 * N;
  localparam int AW  = 4;
  localparam int SAT = 65535;

  logic          clk_in = 1'b0;
  logic          n_reset_in;
  logic          bclk_in;
  logic [2:0]    rgb_top_in;
  logic [2:0]    rgb_bot_in;
  logic          latch_in;
  logic          oe_n_in;
  logic [AW-1:0] addr_in;
  logic [RW-1:0] row_top_out;
  logic [RW-1:0] row_bot_out;
  logic [AW-1:0] row_addr_out;
  logic          row_valid_out;
  logic          row_ready_in = 1'b0;
  logic [15:0]   on_time_out;
  logic          len_err_out;
  logic          overrun_out;
  logic          err_clr_in;

  led_display_panel_rx #(
    .SYS_CLK_FREQ  (100_000_000),
    .NUM_ROW_PIXELS(32),
    .NUM_COL_PIXELS(N)
  ) dut (
    .clk_in       (clk_in),
    .n_reset_in   (n_reset_in),
    .bclk_in      (bclk_in),
    .rgb_top_in   (rgb_top_in),
    .rgb_bot_in   (rgb_bot_in),
    .latch_in     (latch_in),
    .oe_n_in      (oe_n_in),
    .addr_in      (addr_in),
    .row_top_out  (row_top_out),
    .row_bot_out  (row_bot_out),
    .row_addr_out (row_addr_out),
    .row_valid_out(row_valid_out),
    .row_ready_in (row_ready_in),
    .on_time_out  (on_time_out),
    .len_err_out  (len_err_out),
    .overrun_out  (overrun_out),
    .err_clr_in   (err_clr_in)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [RW-1:0] top;
    logic [RW-1:0] bot;
    logic [AW-1:0] addr;
    logic [15:0]   ont;
    logic          lerr;
  } row_t;

  row_t        sb[$];
  logic [2:0]  h_top[N];     // h_top[k] = top pixel pushed k pushes ago
  logic [2:0]  h_bot[N];
  int unsigned px_cnt;       // pixels pushed since last latch / reset
  int unsigned oe_acc;       // clk cycles oe_n was low since last latch
  bit          m_lerr;
  bit          m_ovr;
  bit          ready_en;
  bit          expect_drop;
  int          passed = 0;
  int          total  = 0;

  function automatic void check(input string name, input logic [RW-1:0] act,
                                input logic [RW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < N; k++) begin
      h_top[k] = 3'd0;
      h_bot[k] = 3'd0;
    end
    px_cnt = 0;
    oe_acc = 0;
    m_lerr = 0;
    m_ovr  = 0;
    sb.delete();
  endfunction

  // Monitor: choose ready, then any valid&ready pair completes at the next posedge.
  always @(negedge clk_in) begin
    if (!n_reset_in) begin
      row_ready_in = 1'b0;
      expect_drop  = 1'b0;
    end else begin
      if (expect_drop) begin
        check("valid_drop", row_valid_out, 1'b0);
        expect_drop = 1'b0;
      end
      row_ready_in = ready_en ? 1'($urandom_range(0, 1)) : 1'b0;
      if (row_valid_out && row_ready_in) begin
        if (sb.size() == 0) begin
          check("unexpected_row", row_valid_out, 1'b0);
        end else begin
          row_t e;
          e = sb.pop_front();
          check("row_top", row_top_out, e.top);
          check("row_bot", row_bot_out, e.bot);
          check("row_addr", row_addr_out, e.addr);
          check("on_time", on_time_out, e.ont);
          check("len_err_at_row", len_err_out, e.lerr);
        end
        expect_drop = 1'b1;
      end
    end
  end

  task automatic push_px(input logic [2:0] t, input logic [2:0] b);
    @(negedge clk_in);
    rgb_top_in = t;
    rgb_bot_in = b;
    repeat (2) @(negedge clk_in);
    bclk_in = 1'b1;
    for (int k = N - 1; k > 0; k--) begin
      h_top[k] = h_top[k-1];
      h_bot[k] = h_bot[k-1];
    end
    h_top[0] = t;
    h_bot[0] = b;
    px_cnt++;
    repeat (3) @(negedge clk_in);
    bclk_in = 1'b0;
    repeat (2) @(negedge clk_in);
  endtask

  task automatic push_rand(input int n);
    for (int i = 0; i < n; i++) push_px(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
  endtask

  task automatic oe_low(input int k);
    @(negedge clk_in);
    oe_n_in = 1'b0;
    repeat (k) @(negedge clk_in);
    oe_n_in = 1'b1;
    oe_acc += k;
    repeat (4) @(negedge clk_in);
  endtask

  task automatic do_latch(input logic [AW-1:0] a);
    row_t e;
    @(negedge clk_in);
    addr_in = a;
    repeat (3) @(negedge clk_in);
    latch_in = 1'b1;
    for (int c = 0; c < N; c++) begin
      e.top[3*c +: 3] = h_top[c];
      e.bot[3*c +: 3] = h_bot[c];
    end
    e.addr = a;
    e.ont  = (oe_acc > SAT) ? 16'(SAT) : 16'(oe_acc);
    if (px_cnt != N) m_lerr = 1;
    e.lerr = m_lerr;
    oe_acc = 0;
    px_cnt = 0;
    if (sb.size() > 0) m_ovr = 1;
    else sb.push_back(e);
    repeat (3) @(negedge clk_in);
    latch_in = 1'b0;
    repeat (4) @(negedge clk_in);
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while (sb.size() > 0 && n < 300) begin
      @(negedge clk_in);
      n++;
    end
    check(name, RW'(sb.size()), '0);
    repeat (3) @(negedge clk_in);
  endtask

  task automatic err_clear();
    @(negedge clk_in);
    err_clr_in = 1'b1;
    @(negedge clk_in);
    err_clr_in = 1'b0;
    m_lerr = 0;
    m_ovr  = 0;
    check("clr_len_err", len_err_out, 1'b0);
    check("clr_overrun", overrun_out, 1'b0);
  endtask

  task automatic release_reset();
    @(negedge clk_in);
    n_reset_in = 1'b1;
    // Synchronizers leave reset at 0, so oe_n reads low for two cycles.
    oe_acc = 2;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_reset_in = 1'b0;
    bclk_in    = 1'b0;
    rgb_top_in = '0;
    rgb_bot_in = '0;
    latch_in   = 1'b0;
    oe_n_in    = 1'b1;
    addr_in    = '0;
    err_clr_in = 1'b0;
    ready_en   = 1'b1;
    model_reset();
    repeat (3) @(negedge clk_in);
    check("rst_valid", row_valid_out, 1'b0);
    check("rst_top", row_top_out, '0);
    check("rst_on_time", on_time_out, '0);
    check("rst_flags", {len_err_out, overrun_out}, '0);
    release_reset();

    // Known pattern: top = index mod 8, bot = ~top, addr 5
    for (int i = 0; i < N; i++) push_px(3'(i % 8), ~3'(i % 8));
    do_latch(4'd5);
    wait_empty("drain_pattern");
    check("pattern_len_err", len_err_out, 1'b0);
    check("pattern_overrun", overrun_out, 1'b0);

    // Short and long rows
    push_rand(N - 1);
    do_latch(4'(($urandom_range(0, 15))));
    wait_empty("drain_short");
    check("short_len_err", len_err_out, 1'b1);
    err_clear();
    push_rand(N + 1);
    do_latch(4'(($urandom_range(0, 15))));
    wait_empty("drain_long");
    check("long_len_err", len_err_out, 1'b1);
    err_clear();

    // Overrun: consumer stalls across two rows
    ready_en = 1'b0;
    push_rand(N);
    do_latch(4'd3);
    repeat (5) @(negedge clk_in);
    check("ovr_first_valid", row_valid_out, 1'b1);
    push_rand(N);
    do_latch(4'd12);
    repeat (5) @(negedge clk_in);
    check("ovr_flag", overrun_out, 1'b1);
    check("ovr_hold_top", row_top_out, sb[0].top);
    check("ovr_hold_addr", row_addr_out, sb[0].addr);
    ready_en = 1'b1;
    wait_empty("drain_overrun");
    repeat (20) @(negedge clk_in);
    check("ovr_dropped", row_valid_out, 1'b0);
    check("ovr_sticky", overrun_out, 1'b1);
    err_clear();

    // On-time counting and saturation
    oe_low(500);
    push_rand(N);
    do_latch(4'd7);
    wait_empty("drain_oe500");
    oe_low(66000);
    push_rand(N);
    do_latch(4'd8);
    wait_empty("drain_oesat");

    // Randomized rows with random consumer readiness
    for (int r = 0; r < 4; r++) begin
      int k;
      k = int'($urandom_range(0, 300));
      if (k > 0) oe_low(k);
      push_rand(int'($urandom_range(N - 2, N + 2)));
      do_latch(4'($urandom_range(0, 15)));
      wait_empty("drain_random");
    end
    check("random_overrun", overrun_out, m_ovr);
    check("random_len_err", len_err_out, m_lerr);
    err_clear();

    // Reset in mid-row discards the partial row
    push_rand(30);
    @(negedge clk_in);
    n_reset_in = 1'b0;
    #1;
    check("midrst_valid", row_valid_out, 1'b0);
    check("midrst_top", row_top_out, '0);
    check("midrst_bot", row_bot_out, '0);
    model_reset();
    repeat (3) @(negedge clk_in);
    release_reset();
    repeat (20) @(negedge clk_in);
    check("postrst_no_row", row_valid_out, 1'b0);
    push_rand(N);
    do_latch(4'd9);
    wait_empty("drain_postrst");
    check("postrst_len_err", len_err_out, 1'b0);
    check("postrst_overrun", overrun_out, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
